matriz_determ_ctrl: RTL

Sequencing controller that computes the determinant of an NxN matrix (N = 2..5) by repeatedly driving the existing combinational 3x3 determinant unit. Sits in the coprocessor ULA between the instruction/operand path and the det3 datapath. Performs Laplace expansion along the leading rows, presents one 3x3 minor per cycle, and accumulates signed, coefficient-weighted results into an 8-bit determinant.

---
 rtl/matriz_determ_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/matriz_determ_ctrl.sv
// matriz_determ_ctrl: sequences an NxN determinant (N = 2..5) through an
// external combinational 3x3 determinant unit. It uses Laplace expansion along
// the leading rows, presents one 3x3 minor per cycle, and accumulates the
// signed, coefficient-weighted terms modulo 256.
module matriz_determ_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   size,
  input  logic [199:0] mat_in,
  output logic [199:0] det3_mat,
  input  logic [7:0]   det3_res,
  output logic         busy,
  output logic         done,
  output logic [7:0]   det,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [199:0]      r_mat;
  logic [2:0]        r_n;
  logic [2:0]        r_k;
  logic [1:0]        r_m;
  logic signed [7:0] r_acc;
  logic              r_inv;
  logic              r_done;
  logic [7:0]        r_det;
  logic              r_err;
  logic [199:0]      r_det3_mat;

  logic              w_size_ok;
  logic              w_accept;
  logic              w_last;
  logic              w_busy;
  logic [2:0]        w_k_nxt;
  logic [1:0]        w_m_nxt;
  logic [199:0]      w_minor_nxt;
  logic signed [7:0] w_term;

  // Minor for expansion step (k, m). N=2 is embedded into a 3x3 with a unit
  // corner so the 3x3 unit returns the 2x2 determinant directly. N=4 drops
  // row 0 and column m; N=5 drops rows 0..1 and columns k and c_m, where c_m
  // is the m-th surviving column once k is removed.
  function automatic logic [199:0] build_minor(input logic [199:0] src,
                                               input logic [2:0]   n,
                                               input logic [2:0]   k,
                                               input logic [1:0]   m);
    logic [199:0] res;
    logic [7:0]   si;
    logic [7:0]   di;
    int           kk, mm, cm, lo, hi, row, col;
    res = '0;
    kk  = int'(k);
    mm  = int'(m);
    cm  = (mm >= kk) ? mm + 1 : mm;
    lo  = (kk < cm) ? kk : cm;
    hi  = (kk < cm) ? cm : kk;
    if (n == 3'd2) begin
      res[0 +: 8]  = src[0 +: 8];
      res[8 +: 8]  = src[8 +: 8];
      res[40 +: 8] = src[40 +: 8];
      res[48 +: 8] = src[48 +: 8];
      res[96 +: 8] = 8'd1;
    end else if (n >= 3'd3 && n <= 3'd5) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          row = i;
          col = j;
          if (n == 3'd4) begin
            row = i + 1;
            if (col >= mm) col = col + 1;
          end else if (n == 3'd5) begin
            row = i + 2;
            if (col >= lo) col = col + 1;
            if (col >= hi) col = col + 1;
          end
          si = 8'(row * 40 + col * 8);
          di = 8'(i * 40 + j * 8);
          res[di +: 8] = src[si +: 8];
        end
      end
    end
    return res;
  endfunction

  // Weighted, signed cofactor term for the minor currently on det3_mat.
  // Every multiply truncates to 8 bits; the sign is a two's-complement negate.
  function automatic logic signed [7:0] calc_term(input logic [199:0] src,
                                                  input logic [2:0]   n,
                                                  input logic [2:0]   k,
                                                  input logic [1:0]   m,
                                                  input logic [7:0]   res3);
    logic [7:0] coef;
    logic [7:0] prod;
    logic       neg;
    int         kk, mm, cm;
    kk   = int'(k);
    mm   = int'(m);
    cm   = (mm >= kk) ? mm + 1 : mm;
    coef = 8'd1;
    neg  = 1'b0;
    if (n == 3'd4) begin
      coef = src[8'(mm * 8) +: 8];
      neg  = m[0];
    end else if (n == 3'd5) begin
      coef = src[8'(kk * 8) +: 8] * src[8'(40 + cm * 8) +: 8];
      neg  = k[0] ^ m[0];
    end
    prod = coef * res3;
    if (neg) prod = 8'(-prod);
    return $signed(prod);
  endfunction

  assign w_size_ok = (size >= 3'd2) && (size <= 3'd5);
  assign w_term    = calc_term(r_mat, r_n, r_k, r_m, det3_res);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, counter advance and the minor to present next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b1;
    w_k_nxt     = r_k;
    w_m_nxt     = r_m;
    w_minor_nxt = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (w_size_ok) begin
            w_state_nxt = S_EVAL;
            w_accept    = 1'b1;
            w_minor_nxt = build_minor(mat_in, size, 3'd0, 2'd0);
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_EVAL: begin
        if (r_n == 3'd4) begin
          w_m_nxt = r_m + 2'd1;
          w_last  = (r_m == 2'd3);
        end else if (r_n == 3'd5) begin
          w_m_nxt = r_m + 2'd1;
          if (r_m == 2'd3) begin
            w_k_nxt = r_k + 3'd1;
            w_last  = (r_k == 3'd4);
          end
        end else begin
          w_last = 1'b1;
        end
        if (w_last) w_state_nxt = S_DONE;
        else        w_minor_nxt = build_minor(r_mat, r_n, w_k_nxt, w_m_nxt);
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on an accepted request; ignored while busy.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mat <= mat_in;
      r_n   <= size;
    end
  end

  // Accumulator, counters, minor register and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_k        <= '0;
      r_m        <= '0;
      r_inv      <= 1'b0;
      r_done     <= 1'b0;
      r_det      <= '0;
      r_err      <= 1'b0;
      r_det3_mat <= '0;
    end else begin
      r_done     <= 1'b0;
      r_det3_mat <= w_minor_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_k   <= '0;
            r_m   <= '0;
            r_inv <= !w_size_ok;
          end
        end
        S_EVAL: begin
          r_acc <= r_acc + w_term;
          r_k   <= w_k_nxt;
          r_m   <= w_m_nxt;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_det  <= r_acc;
          r_err  <= r_inv;
        end
        default: ;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign det      = r_det;
  assign err      = r_err;
  assign det3_mat = r_det3_mat;

endmodule
